// File: rtl/estimate_pkg.sv
// Shared command codes, FSM state type and write-back latency for the estimate layer sequencer.
package estimate_pkg;

    localparam logic [2:0] COM_INI   = 3'd0;
    localparam logic [2:0] COM_ACC   = 3'd1;
    localparam logic [2:0] COM_POOL  = 3'd2;
    localparam logic [2:0] COM_NORM  = 3'd3;
    localparam logic [2:0] COM_ACTIV = 3'd4;
    localparam logic [2:0] COM_NOP   = 3'd7;

    localparam int WB_LAT = 3;
    localparam int IDX_W  = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INI,
        ST_ACC,
        ST_POOL,
        ST_NORM,
        ST_ACTIV,
        ST_DRAIN
    } state_t;

    // Command issued in the cycle after the fetch stage sits in a given state.
    function automatic logic [2:0] state_com(input state_t s);
        case (s)
            ST_INI:   return COM_INI;
            ST_ACC:   return COM_ACC;
            ST_POOL:  return COM_POOL;
            ST_NORM:  return COM_NORM;
            ST_ACTIV: return COM_ACTIV;
            default:  return COM_NOP;
        endcase
    endfunction

endpackage

// File: rtl/estimate_wb_pipe.sv
// Fixed-depth valid + output-index delay line that lines ACTIV commands up with the returned activation.
module estimate_wb_pipe
    import estimate_pkg::*;
(
    input  logic             clk,
    input  logic             flush,
    input  logic             push,
    input  logic [IDX_W-1:0] idx,
    output logic             valid,
    output logic [IDX_W-1:0] idx_out
);

    logic [WB_LAT-1:0] valid_reg;
    logic [IDX_W-1:0]  idx_reg [WB_LAT];

    always_ff @(posedge clk) begin
        if (flush) begin
            valid_reg <= '0;
            for (int i = 0; i < WB_LAT; i++) begin
                idx_reg[i] <= '0;
            end
        end else begin
            valid_reg  <= {valid_reg[WB_LAT-2:0], push};
            idx_reg[0] <= idx;
            for (int i = 1; i < WB_LAT; i++) begin
                idx_reg[i] <= idx_reg[i-1];
            end
        end
    end

    assign valid   = valid_reg[WB_LAT-1];
    assign idx_out = idx_reg[WB_LAT-1];

endmodule

// File: rtl/estimate_seq.sv
// Layer sequencer: walks outputs x pool positions x input words and drives the estimate datapath,
// then writes each returned activation word into the output buffer.
module estimate_seq
    import estimate_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  cfg_k,
    input  logic [3:0]  cfg_pool,
    input  logic [11:0] cfg_n,
    input  logic [15:0] cfg_wbase,
    input  logic [15:0] cfg_nbase,
    output logic [15:0] in_addr,
    input  logic [31:0] in_data,
    output logic [2:0]  est_com,
    output logic [15:0] est_addr,
    output logic [31:0] est_data,
    input  logic [31:0] est_activ,
    output logic        out_we,
    output logic [11:0] out_addr,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done
);

    state_t      state_reg;
    logic [7:0]  k_reg;
    logic [3:0]  pool_reg;
    logic [11:0] n_reg;
    logic [15:0] wbase_reg;
    logic [15:0] nbase_reg;
    logic [7:0]  k_cnt_reg;
    logic [3:0]  p_cnt_reg;
    logic [11:0] o_cnt_reg;
    logic [15:0] rd_ptr_reg;
    logic [15:0] in_addr_reg;
    logic        busy_reg;
    logic        zero_done_reg;

    logic [2:0]  com_reg;
    logic [15:0] addr_reg;
    logic [11:0] e_idx_reg;

    logic        cfg_zero;
    logic        wb_push;
    logic        wb_valid;
    logic [11:0] wb_idx;

    assign cfg_zero = (cfg_k == 8'd0) || (cfg_pool == 4'd0) || (cfg_n == 12'd0);

    // Fetch stage: walks the command stream and presents the input-buffer address one cycle ahead.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            busy_reg      <= 1'b0;
            zero_done_reg <= 1'b0;
            k_reg         <= '0;
            pool_reg      <= '0;
            n_reg         <= '0;
            wbase_reg     <= '0;
            nbase_reg     <= '0;
            k_cnt_reg     <= '0;
            p_cnt_reg     <= '0;
            o_cnt_reg     <= '0;
            rd_ptr_reg    <= '0;
            in_addr_reg   <= '0;
        end else begin
            zero_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        k_reg     <= cfg_k;
                        pool_reg  <= cfg_pool;
                        n_reg     <= cfg_n;
                        wbase_reg <= cfg_wbase;
                        nbase_reg <= cfg_nbase;
                        if (cfg_zero) begin
                            zero_done_reg <= 1'b1;
                        end else begin
                            state_reg  <= ST_INI;
                            busy_reg   <= 1'b1;
                            o_cnt_reg  <= '0;
                            rd_ptr_reg <= '0;
                        end
                    end
                end
                ST_INI: begin
                    state_reg   <= ST_ACC;
                    k_cnt_reg   <= '0;
                    p_cnt_reg   <= '0;
                    in_addr_reg <= rd_ptr_reg;
                    rd_ptr_reg  <= rd_ptr_reg + 16'd1;
                end
                ST_ACC: begin
                    if (k_cnt_reg == k_reg - 8'd1) begin
                        state_reg <= ST_POOL;
                    end else begin
                        k_cnt_reg   <= k_cnt_reg + 8'd1;
                        in_addr_reg <= rd_ptr_reg;
                        rd_ptr_reg  <= rd_ptr_reg + 16'd1;
                    end
                end
                ST_POOL: begin
                    if (p_cnt_reg == pool_reg - 4'd1) begin
                        state_reg <= ST_NORM;
                    end else begin
                        state_reg   <= ST_ACC;
                        p_cnt_reg   <= p_cnt_reg + 4'd1;
                        k_cnt_reg   <= '0;
                        in_addr_reg <= rd_ptr_reg;
                        rd_ptr_reg  <= rd_ptr_reg + 16'd1;
                    end
                end
                ST_NORM: begin
                    state_reg <= ST_ACTIV;
                end
                ST_ACTIV: begin
                    if (o_cnt_reg == n_reg - 12'd1) begin
                        state_reg <= ST_DRAIN;
                    end else begin
                        state_reg <= ST_INI;
                        o_cnt_reg <= o_cnt_reg + 12'd1;
                    end
                end
                ST_DRAIN: begin
                    // The only write still in flight here is the last output's.
                    if (wb_valid) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Issue stage: command and parameter address one cycle behind fetch, matching the buffer read.
    always_ff @(posedge clk) begin
        if (reset) begin
            com_reg   <= COM_NOP;
            addr_reg  <= '0;
            e_idx_reg <= '0;
        end else begin
            com_reg   <= state_com(state_reg);
            e_idx_reg <= o_cnt_reg;
            case (state_reg)
                ST_ACC:  addr_reg <= wbase_reg + 16'(k_cnt_reg);
                ST_NORM: addr_reg <= nbase_reg;
                default: addr_reg <= wbase_reg;
            endcase
        end
    end

    assign wb_push = (com_reg == COM_ACTIV);

    estimate_wb_pipe u_wb_pipe (
        .clk     (clk),
        .flush   (reset),
        .push    (wb_push),
        .idx     (e_idx_reg),
        .valid   (wb_valid),
        .idx_out (wb_idx)
    );

    assign in_addr  = in_addr_reg;
    assign est_com  = com_reg;
    assign est_addr = addr_reg;
    assign est_data = (com_reg == COM_ACC) ? in_data : 32'd0;
    assign out_we   = wb_valid;
    assign out_addr = wb_idx;
    assign out_data = wb_valid ? est_activ : 32'd0;
    assign busy     = busy_reg;
    assign done     = zero_done_reg | (wb_valid & (state_reg == ST_DRAIN));

endmodule

// File: tb/tb_estimate_seq.sv
// Bench for estimate_seq: toy datapath + input buffer, per-cycle trace, checks against arithmetic golden values.
module tb_estimate_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  cfg_k;
    logic [3:0]  cfg_pool;
    logic [11:0] cfg_n;
    logic [15:0] cfg_wbase;
    logic [15:0] cfg_nbase;
    logic [15:0] in_addr;
    logic [31:0] in_data = 32'd0;
    logic [2:0]  est_com;
    logic [15:0] est_addr;
    logic [31:0] est_data;
    logic [31:0] est_activ = 32'd0;
    logic        out_we;
    logic [11:0] out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          s;
    logic [31:0] seed;
    logic [31:0] dp_sum = 32'd0;

    logic [2:0]  lg_com    [4096];
    logic [15:0] lg_addr   [4096];
    logic [31:0] lg_data   [4096];
    logic [15:0] lg_inaddr [4096];
    logic        lg_we     [4096];
    logic [11:0] lg_oaddr  [4096];
    logic [31:0] lg_odata  [4096];
    logic        lg_busy   [4096];
    logic        lg_done   [4096];

    estimate_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_k     (cfg_k),
        .cfg_pool  (cfg_pool),
        .cfg_n     (cfg_n),
        .cfg_wbase (cfg_wbase),
        .cfg_nbase (cfg_nbase),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .est_com   (est_com),
        .est_addr  (est_addr),
        .est_data  (est_data),
        .est_activ (est_activ),
        .out_we    (out_we),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Input words are a bijective hash of the address, so every address holds a distinct word.
    function automatic logic [31:0] h(input logic [15:0] a);
        return ({16'd0, a} * 32'h2545_F491) ^ seed;
    endfunction

    function automatic logic [31:0] prm(input logic [15:0] a);
        return {a, ~a} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int ix(input int t);
        return t % 4096;
    endfunction

    // Input buffer with one-cycle read, plus a toy datapath that folds data and parameter words.
    always @(posedge clk) begin
        in_data <= h(in_addr);
        case (est_com)
            3'd0: dp_sum <= 32'd0;
            3'd1: dp_sum <= dp_sum + (est_data ^ prm(est_addr));
            3'd3: dp_sum <= dp_sum ^ prm(est_addr);
            3'd4: est_activ <= dp_sum;
            default: ;
        endcase
    end

    always @(negedge clk) begin
        lg_com[ix(cyc)]    = est_com;
        lg_addr[ix(cyc)]   = est_addr;
        lg_data[ix(cyc)]   = est_data;
        lg_inaddr[ix(cyc)] = in_addr;
        lg_we[ix(cyc)]     = out_we;
        lg_oaddr[ix(cyc)]  = out_addr;
        lg_odata[ix(cyc)]  = out_data;
        lg_busy[ix(cyc)]   = busy;
        lg_done[ix(cyc)]   = done;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cmd(input int t, input logic [2:0] com, input logic [15:0] addr,
                           input logic [31:0] data);
        chk("cmd_com", 32'(lg_com[ix(t)]), 32'(com));
        chk("cmd_addr", 32'(lg_addr[ix(t)]), 32'(addr));
        chk("cmd_data", lg_data[ix(t)], data);
    endtask

    task automatic run_layer(input int k, input int p, input int n, input logic [15:0] wb,
                             input logic [15:0] nb, input bit pokes);
        int          len;
        int          total;
        int          t;
        int          j;
        int          d;
        bit          zero;
        bit          we_exp;
        logic [31:0] acc;
        logic [31:0] gold[$];
        zero  = (k == 0) || (p == 0) || (n == 0);
        len   = p * (k + 1) + 3;
        total = zero ? 12 : n * len + 10;
        cfg_k = 8'(k); cfg_pool = 4'(p); cfg_n = 12'(n); cfg_wbase = wb; cfg_nbase = nb;
        start = 1'b1;
        s = cyc;
        tick;
        start     = 1'b0;
        cfg_k     = 8'($urandom_range(1, 255));
        cfg_pool  = 4'($urandom_range(1, 15));
        cfg_n     = 12'($urandom_range(1, 4095));
        cfg_wbase = 16'($urandom);
        cfg_nbase = 16'($urandom);
        for (int c = 1; c < total; c++) begin
            start = pokes && (c == 5 || c == n * len + 4);
            tick;
        end
        start = 1'b0;
        $display("layer K=%0d P=%0d N=%0d wbase=%04h nbase=%04h start_cycle=%0d pokes=%0d",
                 k, p, n, wb, nb, s, pokes);
        if (zero) begin
            for (t = s; t < s + total; t++) begin
                chk("zero_com", 32'(lg_com[ix(t)]), 32'd7);
                chk("zero_busy", 32'(lg_busy[ix(t)]), 32'd0);
                chk("zero_we", 32'(lg_we[ix(t)]), 32'd0);
                chk("zero_done", 32'(lg_done[ix(t)]), 32'(t == s + 1));
            end
        end else begin
            j = 0;
            for (int o = 0; o < n; o++) begin
                acc = 32'd0;
                for (int pp = 0; pp < p; pp++) begin
                    for (int kk = 0; kk < k; kk++) begin
                        acc = acc + (h(16'(j)) ^ prm(wb + 16'(kk)));
                        j++;
                    end
                end
                gold.push_back(acc ^ prm(nb));
            end
            chk("lead_nop", 32'(lg_com[ix(s + 1)]), 32'd7);
            t = s + 2;
            j = 0;
            for (int o = 0; o < n; o++) begin
                chk_cmd(t, 3'd0, wb, 32'd0); t++;
                for (int pp = 0; pp < p; pp++) begin
                    for (int kk = 0; kk < k; kk++) begin
                        chk_cmd(t, 3'd1, wb + 16'(kk), h(16'(j)));
                        chk("acc_in_addr", 32'(lg_inaddr[ix(t - 1)]), 32'(16'(j)));
                        chk("acc_data_vs_fetch", lg_data[ix(t)], h(lg_inaddr[ix(t - 1)]));
                        j++; t++;
                    end
                    chk_cmd(t, 3'd2, wb, 32'd0); t++;
                end
                chk_cmd(t, 3'd3, nb, 32'd0); t++;
                chk_cmd(t, 3'd4, wb, 32'd0); t++;
            end
            for (; t < s + total; t++) begin
                chk("tail_nop", 32'(lg_com[ix(t)]), 32'd7);
            end
            for (t = s + 1; t < s + total; t++) begin
                d = t - s - 4;
                we_exp = (d > 0) && (d % len == 0) && (d / len <= n);
                chk("out_we", 32'(lg_we[ix(t)]), 32'(we_exp));
                if (we_exp) begin
                    chk("out_addr", 32'(lg_oaddr[ix(t)]), 32'(d / len - 1));
                    chk("out_data", lg_odata[ix(t)], gold[d / len - 1]);
                end
                chk("done", 32'(lg_done[ix(t)]), 32'(t == s + 4 + n * len));
                chk("busy", 32'(lg_busy[ix(t)]), 32'(t <= s + 4 + n * len));
            end
            chk("in_addr_end", 32'(lg_inaddr[ix(s + total - 1)]), 32'(16'(n * p * k - 1)));
        end
    endtask

    initial begin
        seed      = $urandom;
        reset     = 1'b1;
        start     = 1'b0;
        cfg_k     = '0;
        cfg_pool  = '0;
        cfg_n     = '0;
        cfg_wbase = '0;
        cfg_nbase = '0;
        repeat (3) tick;
        $display("reset state check");
        chk("rst_est_com", 32'(est_com), 32'd7);
        chk("rst_est_addr", 32'(est_addr), 32'd0);
        chk("rst_est_data", est_data, 32'd0);
        chk("rst_in_addr", 32'(in_addr), 32'd0);
        chk("rst_out_we", 32'(out_we), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (2) tick;

        run_layer(2, 1, 1, 16'h0100, 16'h0200, 1'b0);
        run_layer(3, 4, 5, 16'($urandom), 16'($urandom), 1'b1);
        run_layer(0, 2, 3, 16'h0010, 16'h0020, 1'b0);
        run_layer(1, 0, 1, 16'h0010, 16'h0020, 1'b0);
        run_layer(1, 1, 0, 16'h0010, 16'h0020, 1'b0);

        // Reset while output 2 of 5 is in its ACC run; output 1's pending write must be dropped.
        cfg_k = 8'd3; cfg_pool = 4'd4; cfg_n = 12'd5; cfg_wbase = 16'h1234; cfg_nbase = 16'h4321;
        start = 1'b1;
        s = cyc;
        tick;
        start = 1'b0;
        repeat (40) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        repeat (80) tick;
        $display("mid-layer reset at cycle %0d (start %0d)", s + 41, s);
        chk("rst_mid_acc", 32'(lg_com[ix(s + 41)]), 32'd1);
        chk("rst_mid_nop", 32'(lg_com[ix(s + 42)]), 32'd7);
        chk("rst_mid_we0", 32'(lg_we[ix(s + 23)]), 32'd1);
        chk("rst_mid_addr0", 32'(lg_oaddr[ix(s + 23)]), 32'd0);
        for (int t = s + 42; t < s + 122; t++) begin
            chk("rst_mid_no_we", 32'(lg_we[ix(t)]), 32'd0);
            chk("rst_mid_com", 32'(lg_com[ix(t)]), 32'd7);
            chk("rst_mid_busy", 32'(lg_busy[ix(t)]), 32'd0);
            chk("rst_mid_done", 32'(lg_done[ix(t)]), 32'd0);
        end
        run_layer(3, 4, 5, 16'h1234, 16'h4321, 1'b0);

        for (int r = 0; r < 4; r++) begin
            run_layer($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(1, 5),
                      (r == 0) ? 16'hFFFE : 16'($urandom), 16'($urandom), 1'(r[0]));
        end
        run_layer(255, 2, 2, 16'hFF80, 16'h0001, 1'b0);
        run_layer(1, 15, 3, 16'h8000, 16'h7FFF, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/estimate_seq.md
# estimate_seq

Layer sequencer for the 32-filter binarized `estimate` datapath. On `start`, it walks `cfg_n` output words, with `cfg_pool` pool positions each and `cfg_k` 32-bit input words per position. For each output it issues the datapath command stream (ini, acc, pool, norm, activ) with aligned parameter-RAM address and input data, then writes the returned 32-bit `activ` vector into the output buffer. It sits between the input/output activation buffers and `estimate`'s `com`/`addr`/`data`/`activ` ports.

## Interface
No parameters. Widths are fixed by the datapath.
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; ignored while `busy`.
- `cfg_k` in 8: acc words per pool position, 1..255.
- `cfg_pool` in 4: pool positions per output, 1..15.
- `cfg_n` in 12: output words per layer.
- `cfg_wbase` in 16: param-RAM row of weight word 0.
- `cfg_nbase` in 16: param-RAM row of norm thresholds.
- `in_addr` out 16: input-buffer read address; the buffer returns `in_data` one cycle later.
- `in_data` in 32: input activation word.
- `est_com` out 3: datapath command.
- `est_addr` out 16: datapath param address.
- `est_data` out 32: datapath data.
- `est_activ` in 32: datapath activation vector.
- `out_we` out 1: output-buffer write strobe.
- `out_addr` out 12: output word index.
- `out_data` out 32: written activation word.
- `busy` out 1: layer in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- Config fields are latched when `start` is accepted.
- If `cfg_n`, `cfg_k` or `cfg_pool` is zero, `done` pulses the next cycle, no command is issued and `busy` stays low.
- FSM states: IDLE, INI, ACC, POOL, NORM, ACTIV, DRAIN.
- Command stream per output o (no gaps):
  - INI, with `est_data`=0.
  - For p = 0..P-1: ACC ×K, then POOL with `est_data`=0.
  - NORM.
  - ACTIV.
- Commands per output: L = P·(K+1)+3.
- Next output's INI follows the ACTIV immediately; after the last ACTIV the FSM enters DRAIN.
- During ACC:
  - `est_addr` = `cfg_wbase`+k.
  - `est_data` = `in_data`.
  - `in_addr` is a running pointer: 0 at start, +1 per ACC, wraps mod 2^16.
- During NORM: `est_addr` = `cfg_nbase`.
- Otherwise: `est_addr` = `cfg_wbase`, `est_data` = 0.
- Idle command is NOP = 3'd7. The datapath ignores it; it is driven in IDLE and DRAIN.
- Write-back:
  - Each ACTIV pushes output index o into a 3-stage delay line.
  - When the entry emerges, the block asserts `out_we` with `out_addr`=o and `out_data`=`est_activ`.
- `done` pulses in the same cycle as the last `out_we`. `busy` falls in the following cycle.
- Reset values: `est_com`=7, `est_addr`=0, `est_data`=0, `in_addr`=0, `out_we`=0, `out_addr`=0, `out_data`=0, `busy`=0, `done`=0.
- Reset mid-layer:
  - Returns to IDLE on the next edge.
  - Flushes the delay line; no further `out_we`.
  - The datapath is left as is; the next INI reinitializes it.

## Timing
- Two-stage issue. Fetch stage F drives `in_addr`. Issue stage E registers `est_com`/`est_addr` one cycle later.
- `est_data` in E is muxed combinationally from `in_data`, so it aligns with the 1-cycle buffer read.
- Param RAM and datapath input registers each add 1 cycle and consume `est_com`/`est_addr` in the same cycle. Command, address and data therefore stay co-aligned.
- With `start` high in cycle S:
  - `busy` is high from S+1.
  - The first INI is on `est_com` in cycle S+2.
  - Output o's ACTIV is in cycle S+1+(o+1)·L.
  - Its `out_we` is 3 cycles later.
  - Last `done` is at S+4+N·L.
- `start` in the same cycle as `done`: ignored, because `busy` is still high.

## Structure
- `estimate_pkg` holds:
  - Command localparams COM_INI=0, COM_ACC=1, COM_POOL=2, COM_NORM=3, COM_ACTIV=4, COM_NOP=7.
  - The FSM state enum.
  - The write-back latency constant WB_LAT=3.
- One sub-module, `estimate_wb_pipe`: the WB_LAT-deep valid+index delay line. It has a flush input driven by reset.

## Test plan
- K=2, P=1, N=1, start at S:
  - `est_com` = 0,1,1,2,3,4 in cycles S+2..S+7.
  - ACC `est_addr` = wbase, wbase+1.
  - `in_addr` = 0,1.
  - `out_we` with `out_addr`=0 at S+10, which is also the `done` cycle.
- K=3, P=4, N=5: 19 commands per output with no gaps, and `in_addr` ends at 59. Then check all of:
  - five writes, addresses 0..4;
  - `done` at S+4+95;
  - output buffer matches the golden model.
- `in_data` distinct per address: every ACC `est_data` equals the word at the `in_addr` of the previous cycle.
- `start` pulsed during busy, and again in the `done` cycle: ignored, with the count of commands and writes unchanged.
- Reset asserted mid-ACC of output 2 of 5: `est_com`=7 next cycle, no further `out_we`, and a fresh start runs cleanly.
- `cfg_k`=0: `done` at S+1, `busy` never high, `est_com` stays 7.
